keypad_scan_encoder: RTL and testbench

//  - Scans the calculator's 4x4 matrix keypad, debounces presses and encodes each

---
 rtl/calc_pkg.sv | 57 +++++
 rtl/col_sync.sv | 29 ++
 rtl/keypad_scan_encoder.sv | 132 +++++++++++++
 tb/tb_keypad_scan_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end and its downstream decoder.
package calc_pkg;

  // Scan FSM state encoding
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [3:0] COLS_IDLE = 4'b1111;  // no column pulled low
  localparam logic [3:0] ROW_RESET = 4'b1110;  // row 0 driven low

  // Calculator function assigned to each key position
  typedef enum logic [3:0] {
    FN_D0  = 4'd0,  FN_D1  = 4'd1,  FN_D2  = 4'd2,  FN_D3  = 4'd3,
    FN_D4  = 4'd4,  FN_D5  = 4'd5,  FN_D6  = 4'd6,  FN_D7  = 4'd7,
    FN_D8  = 4'd8,  FN_D9  = 4'd9,  FN_ADD = 4'd10, FN_SUB = 4'd11,
    FN_MUL = 4'd12, FN_DIV = 4'd13, FN_EQ  = 4'd14, FN_CLR = 4'd15
  } calc_func_e;

  // Key code {row, col} to function; layout is 7 8 9 / | 4 5 6 * | 1 2 3 - | C 0 = +
  function automatic calc_func_e key_to_func(input logic [3:0] code);
    calc_func_e fn;
    case (code)
      4'h0: fn = FN_D7;  4'h1: fn = FN_D8;  4'h2: fn = FN_D9;  4'h3: fn = FN_DIV;
      4'h4: fn = FN_D4;  4'h5: fn = FN_D5;  4'h6: fn = FN_D6;  4'h7: fn = FN_MUL;
      4'h8: fn = FN_D1;  4'h9: fn = FN_D2;  4'hA: fn = FN_D3;  4'hB: fn = FN_SUB;
      4'hC: fn = FN_CLR; 4'hD: fn = FN_D0;  4'hE: fn = FN_EQ;  default: fn = FN_ADD;
    endcase
    return fn;
  endfunction

  // Index of the lowest-numbered low column; column 0 wins ties
  function automatic logic [1:0] col_enc(input logic [3:0] cols_n);
    logic [1:0] idx;
    if (!cols_n[0])      idx = 2'd0;
    else if (!cols_n[1]) idx = 2'd1;
    else if (!cols_n[2]) idx = 2'd2;
    else                 idx = 2'd3;
    return idx;
  endfunction

  // One-hot-low row drive for a row index (ROW_RESET rotated left)
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = ROW_RESET;
      2'd1:    drv = {ROW_RESET[2:0], ROW_RESET[3]};
      2'd2:    drv = {ROW_RESET[1:0], ROW_RESET[3:2]};
      default: drv = {ROW_RESET[0],   ROW_RESET[3:1]};
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchroniser bringing the asynchronous keypad columns into the clck domain.
module col_sync
  import calc_pkg::*;
(
  input  logic       clck,
  input  logic       reste,
  input  logic [3:0] col_n_i,
  output logic [3:0] col_s_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Shift the raw columns through two flops; reset to the idle (all-high) pattern
  always_ff @(posedge clck) begin
    // NOTE: reset is sampled on the clock edge; there is no memory array here, so every flop gets a reset value.
    if (!reste) begin
      meta_q <= COLS_IDLE;
      sync_q <= COLS_IDLE;
    end else begin
      // NOTE: non-blocking assignments so sync_q takes meta_q's pre-edge value, giving two real stages.
      meta_q <= col_n_i;
      sync_q <= meta_q;
    end
  end

  assign col_s_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: row rotation, press/release debounce and {row,col} key encoding.
module keypad_scan_encoder
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clck,
  input  logic       reste,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0]       col_s;
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  col_sync u_col_sync (
    .clck    (clck),
    .reste   (reste),
    .col_n_i (col_n),
    .col_s_o (col_s)
  );

  // State, counter, row index and output registers
  always_ff @(posedge clck) begin
    if (!reste) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      row_idx_q   <= 2'd0;
      pat_q       <= COLS_IDLE;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic: scan rows, debounce the press, wait for a debounced release
  always_comb begin
    // NOTE: every _d starts at its hold value so no branch leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (col_s == COLS_IDLE) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            pat_d   = col_s;
            state_d = DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (col_s != pat_q) begin
          // Bounce or release before the press settled: move on without a strobe
          cnt_d     = '0;
          row_idx_d = row_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d       = '0;
          key_code_d  = {row_idx_q, col_enc(pat_q)};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HELD: begin
        // Extra columns going low are rollover keys and are ignored
        if (col_s == COLS_IDLE) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (col_s != COLS_IDLE) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          row_idx_d  = row_idx_q + 2'd1;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  assign row_n     = row_drive(row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder with a key-matrix model and strobe scoreboard.
module tb_keypad_scan_encoder;

  logic       clck  = 1'b0;
  logic       reste = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Keypad model: a pressed key pulls its columns low only while its row is driven
  logic       key_down  = 1'b0;
  logic [1:0] key_row   = 2'd0;
  logic [3:0] key_cols  = 4'hF;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'hF;

  int tests_run = 0;
  int failed    = 0;
  logic [3:0] exp_q[$];

  assign col_n = force_en ? force_val
               : ((key_down && !row_n[key_row]) ? key_cols : 4'hF);

  keypad_scan_encoder #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8),
    .CNT_W        (4)
  ) dut (
    .clck      (clck),
    .reste     (reste),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clck = ~clck;

  // Scoreboard: every strobe must match the oldest pending press
  always @(negedge clck) begin
    logic [3:0] exp_code;
    if (reste === 1'b1 && key_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected_strobe: key_code=%b with no press pending", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          failed++;
          $display("FAIL sb_key_code: got %b want %b", key_code, exp_code);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clck);
      #1;
    end
  endtask

  // Wait until scanning newly enters row idx (bounded)
  task automatic wait_row(input logic [1:0] idx);
    logic [3:0] target;
    logic [3:0] prev;
    bit seen;
    target = ~(4'b0001 << idx);
    prev   = row_n;
    seen   = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step(1);
      if (row_n === target && prev !== target) seen = 1'b1;
      prev = row_n;
    end
    tests_run++;
    if (!seen) begin
      failed++;
      $display("FAIL wait_row%0d: row_n=%b, wanted %b within 64 cycles", idx, row_n, target);
    end
  endtask

  task automatic wait_held_low(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      step(1);
      if (key_held === 1'b0) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      failed++;
      $display("FAIL %s_release_timeout: key_held=%b, wanted 0 within 64 cycles", name, key_held);
    end
  endtask

  task automatic press(input logic [1:0] row, input logic [3:0] cols);
    key_row  = row;
    key_cols = cols;
    key_down = 1'b1;
  endtask

  task automatic test_reset();
    reste    = 1'b0;
    key_down = 1'b0;
    step(3);
    tests_run++; if (row_n !== 4'b1110) begin failed++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
    tests_run++; if (key_code !== 4'b0000) begin failed++; $display("FAIL reset_key_code: got %b want 0000", key_code); end
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    reste = 1'b1;
    step(3);
    tests_run++; if (row_n !== 4'b1110) begin failed++; $display("FAIL scan_row0_hold: got %b want 1110", row_n); end
    step(1);
    tests_run++; if (row_n !== 4'b1101) begin failed++; $display("FAIL scan_row1: got %b want 1101", row_n); end
    step(4);
    tests_run++; if (row_n !== 4'b1011) begin failed++; $display("FAIL scan_row2: got %b want 1011", row_n); end
  endtask

  // Steady press of row2/col1; strobe 12 cycles after the row is entered
  task automatic test_single_press();
    wait_row(2'd2);
    press(2'd2, 4'b1101);
    exp_q.push_back(4'b1001);
    step(11);
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL press_early_valid: got %b want 0", key_valid); end
    tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL press_early_held: got %b want 0", key_held); end
    step(1);
    tests_run++; if (key_valid !== 1'b1) begin failed++; $display("FAIL press_valid: got %b want 1", key_valid); end
    tests_run++; if (key_code !== 4'b1001) begin failed++; $display("FAIL press_code: got %b want 1001", key_code); end
    tests_run++; if (key_held !== 1'b1) begin failed++; $display("FAIL press_held: got %b want 1", key_held); end
    step(1);
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL press_one_cycle: got %b want 0", key_valid); end
    step(5);
    tests_run++; if (row_n !== 4'b1011) begin failed++; $display("FAIL held_row_frozen: got %b want 1011", row_n); end
    tests_run++; if (key_held !== 1'b1) begin failed++; $display("FAIL held_level: got %b want 1", key_held); end
    key_down = 1'b0;
    // 2 sync cycles + 1 to enter RELEASE + 8 clean cycles
    step(10);
    tests_run++; if (key_held !== 1'b1) begin failed++; $display("FAIL release_early: key_held got %b want 1", key_held); end
    step(1);
    tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL release_held: got %b want 0", key_held); end
    tests_run++; if (row_n !== 4'b0111) begin failed++; $display("FAIL release_next_row: got %b want 0111", row_n); end
  endtask

  // Row0/col2 released after 5 debounce cycles: abort to row1, no strobe
  task automatic test_bounce();
    wait_row(2'd0);
    press(2'd0, 4'b1011);
    step(7);
    key_down = 1'b0;
    step(2);
    tests_run++; if (row_n !== 4'b1110) begin failed++; $display("FAIL bounce_row_hold: got %b want 1110", row_n); end
    step(1);
    tests_run++; if (row_n !== 4'b1101) begin failed++; $display("FAIL bounce_next_row: got %b want 1101", row_n); end
    tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL bounce_held: got %b want 0", key_held); end
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL bounce_valid: got %b want 0", key_valid); end
  endtask

  // Row1 with col0 and col3 low: col0 has priority
  task automatic test_multi_col();
    wait_row(2'd1);
    press(2'd1, 4'b0110);
    exp_q.push_back(4'b0100);
    step(12);
    tests_run++; if (key_valid !== 1'b1) begin failed++; $display("FAIL multi_valid: got %b want 1", key_valid); end
    tests_run++; if (key_code !== 4'b0100) begin failed++; $display("FAIL multi_code: got %b want 0100", key_code); end
    step(1);
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL multi_one_cycle: got %b want 0", key_valid); end
    key_down = 1'b0;
    wait_held_low("multi");
  endtask

  // Release chatter timed so the FSM sees low columns when its count is 5
  task automatic test_release_chatter();
    wait_row(2'd3);
    press(2'd3, 4'b0111);
    exp_q.push_back(4'b1111);
    step(12);
    tests_run++; if (key_code !== 4'b1111) begin failed++; $display("FAIL chatter_code: got %b want 1111", key_code); end
    step(2);
    key_down = 1'b0;
    step(6);
    force_val = 4'b1110;
    force_en  = 1'b1;
    step(2);
    force_en  = 1'b0;
    step(9);
    tests_run++; if (key_held !== 1'b1) begin failed++; $display("FAIL chatter_restart: key_held got %b want 1", key_held); end
    step(1);
    tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL chatter_release: key_held got %b want 0", key_held); end
    tests_run++; if (row_n !== 4'b1110) begin failed++; $display("FAIL chatter_next_row: got %b want 1110", row_n); end
  endtask

  // Reset while debouncing at count 4, key kept down through and after reset
  task automatic test_reset_mid_debounce();
    wait_row(2'd0);
    press(2'd0, 4'b1011);
    step(8);
    reste = 1'b0;
    step(1);
    tests_run++; if (row_n !== 4'b1110) begin failed++; $display("FAIL midrst_row_n: got %b want 1110", row_n); end
    tests_run++; if (key_code !== 4'b0000) begin failed++; $display("FAIL midrst_code: got %b want 0000", key_code); end
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
    tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL midrst_held: got %b want 0", key_held); end
    reste = 1'b1;
    exp_q.push_back(4'b0010);
    step(11);
    tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL midrst_early_valid: got %b want 0", key_valid); end
    step(1);
    tests_run++; if (key_valid !== 1'b1) begin failed++; $display("FAIL midrst_valid_after: got %b want 1", key_valid); end
    tests_run++; if (key_code !== 4'b0010) begin failed++; $display("FAIL midrst_code_after: got %b want 0010", key_code); end
    key_down = 1'b0;
    wait_held_low("midrst");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_col();
    test_release_chatter();
    test_reset_mid_debounce();
    step(2);
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_missing_strobe: %0d expected strobes never seen", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
